// File: rtl/matrix_pkg.sv
// Shared definitions for the 4x4 matrix stages (inverse and matrix-vector).
// Q20.12 element format, saturation bounds, FSM state type and index helpers.
package matrix_pkg;

    localparam int N         = 4;
    localparam int ELEM_W    = 32;
    localparam int FRAC_BITS = 12;

    // Full product of two elements (Q40.24) and the accumulator that sums
    // N of them without any chance of internal overflow.
    localparam int PROD_W = 2 * ELEM_W;
    localparam int ACC_W  = PROD_W + 2;

    // Q20.12 saturation bounds.
    localparam logic signed [ELEM_W-1:0] SAT_MAX = 32'sh7FFF_FFFF;
    localparam logic signed [ELEM_W-1:0] SAT_MIN = 32'sh8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } mv_state_t;

    typedef logic [1:0] idx_t;

    // Row-major element index of (r,c) in a 4x4 matrix.
    function automatic logic [3:0] elem_idx(input idx_t r, input idx_t c);
        return {r, c};
    endfunction

    // Bit offset of element (r,c) inside a packed row-major matrix.
    function automatic int unsigned elem_off(input idx_t r, input idx_t c);
        return (N * int'(r) + int'(c)) * ELEM_W;
    endfunction

endpackage

// File: rtl/fxp_shift_sat.sv
// Wide signed value -> narrow fixed-point element: arithmetic right shift
// (floor rounding) followed by saturation to the signed output range.
// The clip flag reports that saturation took place.
import matrix_pkg::*;

module fxp_shift_sat #(
    parameter int IN_W  = ACC_W,
    parameter int OUT_W = ELEM_W,
    parameter int SHIFT = FRAC_BITS
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    clip
);

    localparam logic signed [OUT_W-1:0] MAX_V = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] MIN_V = {1'b1, {(OUT_W-1){1'b0}}};

    logic signed [IN_W-1:0] shifted;
    logic                   all_ones;
    logic                   all_zeros;

    // The value fits when every bit from the output sign bit upward is a copy of the sign.
    always_comb begin
        shifted   = din >>> SHIFT;
        all_ones  = &shifted[IN_W-1:OUT_W-1];
        all_zeros = ~|shifted[IN_W-1:OUT_W-1];
        clip      = !(all_ones || all_zeros);
        if (!clip) begin
            dout = shifted[OUT_W-1:0];
        end else if (shifted[IN_W-1]) begin
            dout = MIN_V;
        end else begin
            dout = MAX_V;
        end
    end

endmodule

// File: rtl/matvec_mult4.sv
// x = M * v for a 4x4 Q20.12 matrix and 4-vector using one shared
// multiply-accumulate unit stepped over 16 cycles. Start/done is a level
// handshake: done holds until start is seen low, and a new operation needs
// start to drop first.
import matrix_pkg::*;

module matvec_mult4 #(
    parameter int W    = ELEM_W,
    parameter int FRAC = FRAC_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [N*N*W-1:0]     Min,
    input  logic [N*W-1:0]       Vin,
    output logic [N*W-1:0]       Xout,
    output logic                 done,
    output logic                 busy,
    output logic                 ovf
);

    localparam int PW = 2 * W;
    localparam int AW = PW + 2;

    mv_state_t state;

    // Operands captured on entry to MAC; later input changes are ignored.
    logic signed [W-1:0] m_op [N*N];
    logic signed [W-1:0] v_op [N];
    logic signed [W-1:0] m_in [N*N];
    logic signed [W-1:0] v_in [N];

    idx_t row;
    idx_t col;

    logic signed [W-1:0]  m_sel;
    logic signed [W-1:0]  v_sel;
    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] acc_sum;
    logic signed [W-1:0]  y;
    logic                 clip;

    // Completed rows are staged here so Xout only ever shows a full result.
    logic [N*W-1:0] x_stage;
    logic [N*W-1:0] x_next;

    genvar gi;

    generate
        for (gi = 0; gi < N*N; gi++) begin : g_m_unpack
            assign m_in[gi] = Min[gi*W +: W];
        end
        for (gi = 0; gi < N; gi++) begin : g_v_unpack
            assign v_in[gi] = Vin[gi*W +: W];
        end
    endgenerate

    // Shared MAC datapath: one element product per cycle added to the running row sum.
    always_comb begin
        m_sel   = m_op[elem_idx(row, col)];
        v_sel   = v_op[col];
        prod    = PW'(m_sel) * PW'(v_sel);
        acc_sum = acc + AW'(prod);
    end

    fxp_shift_sat #(
        .IN_W  (AW),
        .OUT_W (W),
        .SHIFT (FRAC)
    ) u_shift_sat (
        .din  (acc_sum),
        .dout (y),
        .clip (clip)
    );

    // Staged result with the row currently finishing dropped into its slot.
    always_comb begin
        x_next = x_stage;
        x_next[row*W +: W] = y;
    end

    // Control FSM with registered handshake outputs, counters and accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            acc     <= '0;
            row     <= '0;
            col     <= '0;
            x_stage <= '0;
            Xout    <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
            ovf     <= 1'b0;
            for (int i = 0; i < N*N; i++) m_op[i] <= '0;
            for (int i = 0; i < N; i++)   v_op[i] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        for (int i = 0; i < N*N; i++) m_op[i] <= m_in[i];
                        for (int i = 0; i < N; i++)   v_op[i] <= v_in[i];
                        acc   <= '0;
                        row   <= '0;
                        col   <= '0;
                        ovf   <= 1'b0;
                        busy  <= 1'b1;
                        state <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    if (col == 2'd3) begin
                        x_stage <= x_next;
                        acc     <= '0;
                        col     <= '0;
                        row     <= row + 2'd1;
                        if (clip) begin
                            ovf <= 1'b1;
                        end
                        if (row == 2'd3) begin
                            Xout  <= x_next;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= ST_DONE;
                        end
                    end else begin
                        acc <= acc_sum;
                        col <= col + 2'd1;
                    end
                end
                ST_DONE: begin
                    if (!start) begin
                        done  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
